// File: rtl/lpc_pkg.sv
// Shared types, field offsets and helpers for the LPC encoder/decoder pair.
package lpc_pkg;

    localparam int unsigned LPC_BYTES  = 8;
    localparam int unsigned LPC_BEATS  = 4;
    localparam int unsigned LPC_CW_W   = 80;
    localparam int unsigned PH_LSB     = 72;
    localparam int unsigned PV_LSB     = 64;
    localparam int unsigned BEAT_W     = 16;
    localparam int unsigned BEAT_IDX_W = 2;
    localparam int unsigned PAYLOAD_W  = 8 * LPC_BYTES;

    typedef enum logic [1:0] {IDLE, DECODE, SEND} state_t;
    typedef enum logic [1:0] {CLEAN, CORR_DATA, CORR_PAR, UNCORR} status_t;

    // True when exactly one bit of x is set
    function automatic logic is_onehot8(input logic [7:0] x);
        return (x != 8'h00) && ((x & (x - 8'h01)) == 8'h00);
    endfunction

    // Position of the set bit in a one-hot byte
    function automatic logic [2:0] onehot_idx8(input logic [7:0] x);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Beat k carries {src[2k], src[2k+1]}, even byte in the upper half
    function automatic logic [BEAT_W-1:0] beat_of(input logic [LPC_CW_W-1:0] cw,
                                                  input logic [BEAT_IDX_W-1:0] k);
        logic [PAYLOAD_W-1:0] sh;
        sh = cw[PAYLOAD_W-1:0] >> {k, 4'b0000};
        return {sh[7:0], sh[15:8]};
    endfunction

endpackage

// File: rtl/lpc_if.sv
// Codeword input and AXI-Stream output bundle of the LPC decoder.
interface lpc_if;
    import lpc_pkg::*;

    logic                IN_VALID;
    logic                IN_LAST;
    logic [LPC_CW_W-1:0] IN_DATA;
    logic                IN_READY;
    logic [BEAT_W-1:0]   TDATA;
    logic                TVALID;
    logic                TLAST;
    logic                TUSER;
    logic                TREADY;
    logic                ERR_CORR;
    logic                ERR_UNCORR;

    modport master (
        output IN_VALID, IN_LAST, IN_DATA, TREADY,
        input  IN_READY, TDATA, TVALID, TLAST, TUSER, ERR_CORR, ERR_UNCORR
    );

    modport slave (
        input  IN_VALID, IN_LAST, IN_DATA, TREADY,
        output IN_READY, TDATA, TVALID, TLAST, TUSER, ERR_CORR, ERR_UNCORR
    );

endinterface

// File: rtl/lpc_syndrome.sv
// Combinational syndrome computation and error classification for one codeword.
module lpc_syndrome
    import lpc_pkg::*;
(
    input  logic [LPC_CW_W-1:0] cw,
    output status_t             status,
    output logic [2:0]          err_byte,
    output logic [2:0]          err_bit
);

    logic [7:0] rs;
    logic [7:0] cs;

    // Row syndrome per source byte, column syndrome across all bytes and ph
    always_comb begin
        rs = 8'h00;
        cs = cw[PH_LSB +: 8];
        for (int i = 0; i < LPC_BYTES; i++) begin
            rs[i] = cw[PV_LSB + i] ^ (^cw[8*i +: 8]);
            cs    = cs ^ cw[8*i +: 8];
        end
    end

    // Single row+column hit locates a data bit; a lone hit is a parity bit
    always_comb begin
        status   = UNCORR;
        err_byte = onehot_idx8(rs);
        err_bit  = onehot_idx8(cs);
        if (rs == 8'h00 && cs == 8'h00) begin
            status = CLEAN;
        end else if (is_onehot8(rs) && is_onehot8(cs)) begin
            status = CORR_DATA;
        end else if ((is_onehot8(rs) && cs == 8'h00) || (rs == 8'h00 && is_onehot8(cs))) begin
            status = CORR_PAR;
        end
    end

endmodule

// File: rtl/lpc_decoder.sv
// LPC receive side: correct single-bit errors and re-serialise as 4-beat AXI-Stream.
module lpc_decoder
    import lpc_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter bit          CORRECT_EN = 1'b1
) (
    input  logic             ACLK,
    input  logic             ARESET_N,
    lpc_if.slave             bus,
    output logic [CNT_W-1:0] CORR_CNT,
    output logic [CNT_W-1:0] UNCORR_CNT
);

    state_t                state_q, state_d;
    logic [LPC_CW_W-1:0]   cw_q, cw_d, cw_fix;
    logic                  last_q, last_d;
    logic [BEAT_IDX_W-1:0] beat_q, beat_d;
    logic                  in_ready_q, in_ready_d;
    logic                  tvalid_q, tvalid_d;
    logic [BEAT_W-1:0]     tdata_q, tdata_d;
    logic                  tlast_q, tlast_d;
    logic                  tuser_q, tuser_d;
    logic                  err_corr_q, err_corr_d;
    logic                  err_uncorr_q, err_uncorr_d;
    logic [CNT_W-1:0]      corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]      uncorr_cnt_q, uncorr_cnt_d;

    status_t               status;
    logic [2:0]            err_byte;
    logic [2:0]            err_bit;

    lpc_syndrome u_syndrome (
        .cw       (cw_q),
        .status   (status),
        .err_byte (err_byte),
        .err_bit  (err_bit)
    );

    // Flip the located data bit when correction is enabled
    always_comb begin
        cw_fix = cw_q;
        if (CORRECT_EN && status == CORR_DATA) begin
            cw_fix[7'({err_byte, err_bit})] = ~cw_q[7'({err_byte, err_bit})];
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        cw_d         = cw_q;
        last_d       = last_q;
        beat_d       = beat_q;
        in_ready_d   = in_ready_q;
        tvalid_d     = tvalid_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        err_corr_d   = err_corr_q;
        err_uncorr_d = err_uncorr_q;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.IN_VALID && in_ready_q) begin
                    cw_d       = bus.IN_DATA;
                    last_d     = bus.IN_LAST;
                    in_ready_d = 1'b0;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                cw_d         = cw_fix;
                beat_d       = '0;
                tdata_d      = beat_of(cw_fix, '0);
                tvalid_d     = 1'b1;
                tuser_d      = 1'b1;
                tlast_d      = 1'b0;
                err_corr_d   = (status == CORR_DATA) || (status == CORR_PAR);
                err_uncorr_d = (status == UNCORR);
                if (err_corr_d && corr_cnt_q != {CNT_W{1'b1}}) begin
                    corr_cnt_d = corr_cnt_q + CNT_W'(1);
                end
                if (err_uncorr_d && uncorr_cnt_q != {CNT_W{1'b1}}) begin
                    uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
                end
                state_d = SEND;
            end
            SEND: begin
                if (bus.TREADY) begin
                    if (beat_q == BEAT_IDX_W'(LPC_BEATS - 1)) begin
                        tvalid_d     = 1'b0;
                        tdata_d      = '0;
                        tuser_d      = 1'b0;
                        tlast_d      = 1'b0;
                        err_corr_d   = 1'b0;
                        err_uncorr_d = 1'b0;
                        in_ready_d   = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        beat_d  = beat_q + BEAT_IDX_W'(1);
                        tdata_d = beat_of(cw_q, beat_q + BEAT_IDX_W'(1));
                        tuser_d = 1'b0;
                        tlast_d = (beat_q == BEAT_IDX_W'(LPC_BEATS - 2)) ? last_q : 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            state_q      <= IDLE;
            cw_q         <= '0;
            last_q       <= 1'b0;
            beat_q       <= '0;
            in_ready_q   <= 1'b1;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            err_corr_q   <= 1'b0;
            err_uncorr_q <= 1'b0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            cw_q         <= cw_d;
            last_q       <= last_d;
            beat_q       <= beat_d;
            in_ready_q   <= in_ready_d;
            tvalid_q     <= tvalid_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            err_corr_q   <= err_corr_d;
            err_uncorr_q <= err_uncorr_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign bus.IN_READY   = in_ready_q;
    assign bus.TVALID     = tvalid_q;
    assign bus.TDATA      = tdata_q;
    assign bus.TLAST      = tlast_q;
    assign bus.TUSER      = tuser_q;
    assign bus.ERR_CORR   = err_corr_q;
    assign bus.ERR_UNCORR = err_uncorr_q;
    assign CORR_CNT       = corr_cnt_q;
    assign UNCORR_CNT     = uncorr_cnt_q;

endmodule

// File: tb/tb_lpc_decoder.sv
// Directed bench for lpc_decoder: a correcting instance plus a detect-only one
// with 2-bit counters, both fed the same codewords and TREADY.
`timescale 1ns/1ps
module tb_lpc_decoder;

    localparam logic [79:0] CW_CLEAN = 80'h08CB_0807060504030201;
    localparam logic [79:0] CW_DATA  = 80'h08CB_08070E0504030201;
    localparam logic [79:0] CW_PAR   = 80'h09CB_0807060504030201;
    localparam logic [79:0] CW_DBL   = 80'h08CB_0807060504030300;
    localparam logic [63:0] B_CLEAN  = 64'h0102_0304_0506_0708;

    logic ACLK = 1'b0;
    logic ARESET_N = 1'b0;
    lpc_if bus();
    lpc_if bus_nc();
    logic [15:0] corr_cnt, uncorr_cnt;
    logic [1:0]  nc_corr_cnt, nc_uncorr_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] f_beats, f_nc_beats;
    logic [3:0]  f_valid, f_user, f_last, f_corr, f_uncorr, f_nc_corr;
    int          f_wait;

    always #5 ACLK = ~ACLK;

    assign bus_nc.IN_VALID = bus.IN_VALID;
    assign bus_nc.IN_LAST  = bus.IN_LAST;
    assign bus_nc.IN_DATA  = bus.IN_DATA;
    assign bus_nc.TREADY   = bus.TREADY;

    lpc_decoder #(.CNT_W(16), .CORRECT_EN(1'b1)) dut (
        .ACLK(ACLK), .ARESET_N(ARESET_N), .bus(bus.slave),
        .CORR_CNT(corr_cnt), .UNCORR_CNT(uncorr_cnt)
    );

    lpc_decoder #(.CNT_W(2), .CORRECT_EN(1'b0)) dut_nc (
        .ACLK(ACLK), .ARESET_N(ARESET_N), .bus(bus_nc.slave),
        .CORR_CNT(nc_corr_cnt), .UNCORR_CNT(nc_uncorr_cnt)
    );

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Offer one codeword until accepted (bounded); ok=0 if never accepted
    task automatic send_cw(input logic [79:0] cw, input logic last, output bit ok);
        bus.IN_DATA  = cw;
        bus.IN_LAST  = last;
        bus.IN_VALID = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            ok = bus.IN_READY;
            tick();
        end
        bus.IN_VALID = 1'b0;
    endtask

    // Record one frame with TREADY high; beat 0 ends up in the top 16 bits
    task automatic capture_frame();
        bus.TREADY = 1'b1;
        f_wait = 0;
        f_beats = '0;
        f_nc_beats = '0;
        while (!bus.TVALID && f_wait < 10) begin
            tick();
            f_wait++;
        end
        for (int k = 0; k < 4; k++) begin
            f_valid[k]   = bus.TVALID;
            f_user[k]    = bus.TUSER;
            f_last[k]    = bus.TLAST;
            f_corr[k]    = bus.ERR_CORR;
            f_uncorr[k]  = bus.ERR_UNCORR;
            f_nc_corr[k] = bus_nc.ERR_CORR;
            f_beats      = {f_beats[47:0], bus.TDATA};
            f_nc_beats   = {f_nc_beats[47:0], bus_nc.TDATA};
            tick();
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_tests++;
        if ({bus.IN_READY, bus.TVALID, bus.TLAST, bus.TUSER, bus.ERR_CORR, bus.ERR_UNCORR} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 100000", {bus.IN_READY, bus.TVALID, bus.TLAST, bus.TUSER, bus.ERR_CORR, bus.ERR_UNCORR});
        end
        n_tests++;
        if ({bus.TDATA, corr_cnt, uncorr_cnt} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_data_cnt got %h want 0", {bus.TDATA, corr_cnt, uncorr_cnt});
        end
        ARESET_N = 1'b1;
        tick();
        n_tests++;
        if ({bus.IN_READY, bus.TVALID} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release got %b want 10", {bus.IN_READY, bus.TVALID});
        end
    endtask

    task automatic test_clean();
        bit ok;
        send_cw(CW_CLEAN, 1'b1, ok);
        n_tests++;
        if (!ok || bus.TVALID !== 1'b0 || bus.IN_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_accept got ok=%0d tvalid=%b ready=%b want 1 0 0", ok, bus.TVALID, bus.IN_READY);
        end
        capture_frame();
        n_tests++;
        if (f_wait != 1 || f_valid !== 4'hF) begin
            n_fail++;
            $display("FAIL clean_latency got wait=%0d valid=%b want 1 1111", f_wait, f_valid);
        end
        n_tests++;
        if (f_beats !== B_CLEAN) begin
            n_fail++;
            $display("FAIL clean_beats got %h want %h", f_beats, B_CLEAN);
        end
        n_tests++;
        if ({f_user, f_last, f_corr, f_uncorr} !== 16'b0001_1000_0000_0000) begin
            n_fail++;
            $display("FAIL clean_sideband got %b want 0001100000000000", {f_user, f_last, f_corr, f_uncorr});
        end
        n_tests++;
        if ({bus.TVALID, bus.IN_READY, bus.ERR_CORR, corr_cnt} !== {3'b010, 16'd0}) begin
            n_fail++;
            $display("FAIL clean_after got tv=%b rdy=%b ec=%b cnt=%0d want 0 1 0 0", bus.TVALID, bus.IN_READY, bus.ERR_CORR, corr_cnt);
        end
    endtask

    task automatic test_data_err();
        bit ok;
        send_cw(CW_DATA, 1'b1, ok);
        capture_frame();
        n_tests++;
        if (!ok || f_beats !== B_CLEAN) begin
            n_fail++;
            $display("FAIL data_err_beats got %h want %h", f_beats, B_CLEAN);
        end
        n_tests++;
        if ({f_corr, f_uncorr} !== 8'hF0 || corr_cnt !== 16'd1 || uncorr_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL data_err_flags got corr=%b unc=%b cc=%0d uc=%0d want 1111 0000 1 0", f_corr, f_uncorr, corr_cnt, uncorr_cnt);
        end
        n_tests++;
        if (f_nc_beats !== 64'h0102_0304_050E_0708 || f_nc_corr !== 4'hF || nc_corr_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL data_err_nocorrect got %h corr=%b cnt=%0d want 01020304050e0708 1111 1", f_nc_beats, f_nc_corr, nc_corr_cnt);
        end
    endtask

    task automatic test_parity_err();
        bit ok;
        send_cw(CW_PAR, 1'b1, ok);
        capture_frame();
        n_tests++;
        if (!ok || f_beats !== B_CLEAN || f_nc_beats !== B_CLEAN) begin
            n_fail++;
            $display("FAIL parity_beats got %h nc %h want %h", f_beats, f_nc_beats, B_CLEAN);
        end
        n_tests++;
        if (f_corr !== 4'hF || f_uncorr !== 4'h0 || corr_cnt !== 16'd2 || nc_corr_cnt !== 2'd2) begin
            n_fail++;
            $display("FAIL parity_flags got corr=%b unc=%b cc=%0d nc=%0d want 1111 0000 2 2", f_corr, f_uncorr, corr_cnt, nc_corr_cnt);
        end
    endtask

    task automatic test_double_err();
        bit ok;
        send_cw(CW_DBL, 1'b1, ok);
        capture_frame();
        n_tests++;
        if (!ok || f_beats !== 64'h0003_0304_0506_0708) begin
            n_fail++;
            $display("FAIL double_beats got %h want 0003030405060708", f_beats);
        end
        n_tests++;
        if ({f_corr, f_uncorr} !== 8'h0F || uncorr_cnt !== 16'd1 || corr_cnt !== 16'd2 || nc_uncorr_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL double_flags got corr=%b unc=%b uc=%0d cc=%0d nuc=%0d want 0000 1111 1 2 1", f_corr, f_uncorr, uncorr_cnt, corr_cnt, nc_uncorr_cnt);
        end
    endtask

    task automatic test_saturation();
        bit ok;
        send_cw(CW_DATA, 1'b0, ok);
        capture_frame();
        n_tests++;
        if (!ok || f_last !== 4'b0000 || f_user !== 4'b0001) begin
            n_fail++;
            $display("FAIL nolast_sideband got last=%b user=%b want 0000 0001", f_last, f_user);
        end
        n_tests++;
        if (nc_corr_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_reach got %0d want 3", nc_corr_cnt);
        end
        send_cw(CW_DATA, 1'b0, ok);
        capture_frame();
        n_tests++;
        if (nc_corr_cnt !== 2'd3 || corr_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL sat_hold got nc=%0d cc=%0d want 3 4", nc_corr_cnt, corr_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit hs;
        logic [15:0] exp_b [4];
        exp_b = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
        bus.IN_DATA  = CW_CLEAN;
        bus.IN_LAST  = 1'b1;
        bus.IN_VALID = 1'b1;
        bus.TREADY   = 1'b1;
        hs = 1'b0;
        for (int c = 0; c < 20 && !hs; c++) begin
            hs = bus.IN_READY;
            tick();
        end
        tick();
        n_tests++;
        if (!hs || {bus.TVALID, bus.IN_READY, bus.TDATA} !== {2'b10, 16'h0102}) begin
            n_fail++;
            $display("FAIL bp_beat0 got hs=%0d tv=%b rdy=%b data=%h want 1 1 0 0102", hs, bus.TVALID, bus.IN_READY, bus.TDATA);
        end
        tick();
        bus.TREADY = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if ({bus.TVALID, bus.IN_READY, bus.TUSER, bus.TLAST, bus.TDATA} !== {4'b1000, 16'h0304}) begin
                n_fail++;
                $display("FAIL bp_hold%0d got tv=%b rdy=%b tu=%b tl=%b data=%h want 1 0 0 0 0304", c, bus.TVALID, bus.IN_READY, bus.TUSER, bus.TLAST, bus.TDATA);
            end
            tick();
        end
        bus.TREADY = 1'b1;
        for (int k = 1; k < 4; k++) begin
            n_tests++;
            if ({bus.TVALID, bus.IN_READY, bus.TDATA} !== {2'b10, exp_b[k]}) begin
                n_fail++;
                $display("FAIL bp_beat%0d got tv=%b rdy=%b data=%h want 1 0 %h", k, bus.TVALID, bus.IN_READY, bus.TDATA, exp_b[k]);
            end
            tick();
        end
        n_tests++;
        if ({bus.TVALID, bus.IN_READY} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_done got tv=%b rdy=%b want 0 1", bus.TVALID, bus.IN_READY);
        end
        tick();
        bus.IN_VALID = 1'b0;
        n_tests++;
        if (bus.IN_READY !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_next_taken got rdy=%b want 0", bus.IN_READY);
        end
        capture_frame();
        n_tests++;
        if (f_wait != 1 || f_beats !== B_CLEAN) begin
            n_fail++;
            $display("FAIL bp_next_frame got wait=%0d beats=%h want 1 %h", f_wait, f_beats, B_CLEAN);
        end
    endtask

    task automatic test_back_to_back();
        int hs_cnt, first, second, beats;
        hs_cnt = 0; first = -1; second = -1; beats = 0;
        bus.IN_DATA  = CW_CLEAN;
        bus.IN_LAST  = 1'b1;
        bus.IN_VALID = 1'b1;
        bus.TREADY   = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus.TVALID && bus.TREADY) beats++;
            if (bus.IN_VALID && bus.IN_READY) begin
                if (hs_cnt == 0) first = c; else second = c;
                hs_cnt++;
            end
            tick();
            if (hs_cnt == 2) bus.IN_VALID = 1'b0;
            if (hs_cnt == 2 && bus.IN_READY && !bus.TVALID) break;
        end
        n_tests++;
        if (hs_cnt != 2 || second - first != 6) begin
            n_fail++;
            $display("FAIL b2b_period got hs=%0d gap=%0d want 2 6", hs_cnt, second - first);
        end
        n_tests++;
        if (beats != 8) begin
            n_fail++;
            $display("FAIL b2b_beats got %0d want 8", beats);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        send_cw(CW_DATA, 1'b1, ok);
        bus.TREADY = 1'b1;
        for (int c = 0; c < 10 && !bus.TVALID; c++) tick();
        tick();
        tick();
        n_tests++;
        if (!ok || bus.TVALID !== 1'b1 || bus.TDATA !== 16'h0506 || corr_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL rst_mid_pre got tv=%b data=%h cc=%0d want 1 0506 5", bus.TVALID, bus.TDATA, corr_cnt);
        end
        ARESET_N = 1'b0;
        #1;
        n_tests++;
        if ({bus.TVALID, bus.IN_READY, bus.ERR_CORR, corr_cnt, uncorr_cnt} !== {3'b010, 32'h0}) begin
            n_fail++;
            $display("FAIL rst_mid_async got tv=%b rdy=%b ec=%b cc=%0d uc=%0d want 0 1 0 0 0", bus.TVALID, bus.IN_READY, bus.ERR_CORR, corr_cnt, uncorr_cnt);
        end
        tick();
        ARESET_N = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_tests++;
            if ({bus.TVALID, bus.IN_READY} !== 2'b01) begin
                n_fail++;
                $display("FAIL rst_mid_quiet%0d got tv=%b rdy=%b want 0 1", c, bus.TVALID, bus.IN_READY);
            end
        end
        send_cw(CW_CLEAN, 1'b1, ok);
        capture_frame();
        n_tests++;
        if (!ok || f_beats !== B_CLEAN || f_corr !== 4'h0 || f_user !== 4'b0001 || corr_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_mid_next got beats=%h corr=%b user=%b cc=%0d want %h 0000 0001 0", f_beats, f_corr, f_user, corr_cnt, B_CLEAN);
        end
    endtask

    initial begin
        bus.IN_VALID = 1'b0;
        bus.IN_LAST  = 1'b0;
        bus.IN_DATA  = '0;
        bus.TREADY   = 1'b0;
        test_reset();
        test_clean();
        test_data_err();
        test_parity_err();
        test_double_err();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
